// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 receive path.
//   ps2_state_e            - receiver FSM states
//   DATA_BITS              - data bits per PS/2 frame
//   DEFAULT_TIMEOUT_CYCLES - default inter-edge timeout in clk cycles
package ps2_pkg;

    localparam int unsigned DATA_BITS              = 8;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 50000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

endpackage

// File: rtl/ps2_fifo.sv
// ps2_fifo: single-clock synchronous FIFO with registered empty/full flags.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   wr_en, wr_data - push request and byte; ignored when full unless a pop
//                    happens in the same cycle
//   rd_en          - pop request; ignored when empty
//   rd_data_c      - head entry, combinational from the read pointer
//   empty, full    - registered occupancy flags
module ps2_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data_c,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             empty_q,  empty_d;
    logic             full_q,   full_d;

    logic rd_ok;
    logic wr_ok;

    // A pop frees the slot a simultaneous push on a full FIFO needs.
    assign rd_ok = rd_en && !empty_q;
    assign wr_ok = wr_en && (!full_q || rd_ok);

    // Pointer/occupancy next-state; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (wr_ok && !rd_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - CNT_W'(1);
        end
        empty_d = (count_d == CNT_W'(0));
        full_d  = (count_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    // Storage needs no reset; contents are only visible while non-empty.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data_c = mem[rd_ptr_q];
    assign empty     = empty_q;
    assign full      = full_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver feeding a byte FIFO.
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   ps2Clk, ps2Data    - raw asynchronous PS/2 lines
//   rdStrobe           - pop one byte from the FIFO
//   dataOut, dataValid - FIFO head byte and non-empty flag
//   overflow           - sticky, a received byte was dropped on a full FIFO
//   frameErr           - sticky, parity/stop/timeout error seen
//   ps2ClkOe           - open-drain pull-low enable for ps2Clk
// Build option: define PS2_INHIBIT_EN to hold the PS/2 clock low while the
// FIFO is full and the receiver is idle; otherwise ps2ClkOe stays 0.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    input  logic       rdStrobe,
    output logic [7:0] dataOut,
    output logic       dataValid,
    output logic       overflow,
    output logic       frameErr,
    output logic       ps2ClkOe
);

    localparam int unsigned BIT_W = $clog2(DATA_BITS);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    logic                 clk_meta_q,  clk_meta_d;
    logic                 clk_sync_q,  clk_sync_d;
    logic                 clk_d1_q,    clk_d1_d;
    logic                 clk_d2_q,    clk_d2_d;
    logic                 data_meta_q, data_meta_d;
    logic                 data_sync_q, data_sync_d;
    logic                 fall_q,      fall_d;
    logic                 fall_data_q, fall_data_d;
    ps2_state_e           state_q,     state_d;
    logic [BIT_W-1:0]     bit_cnt_q,   bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,     shift_d;
    logic                 par_ok_q,    par_ok_d;
    logic [TO_W-1:0]      timeout_q,   timeout_d;
    logic                 push_q,      push_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overflow_q,  overflow_d;
    logic                 oe_q,        oe_d;

    logic fifo_empty;
    logic fifo_full;

    // Synchronisers, fall detector, receiver FSM and sticky flags.
    always_comb begin
        clk_meta_d  = ps2Clk;
        clk_sync_d  = clk_meta_q;
        clk_d1_d    = clk_sync_q;
        clk_d2_d    = clk_d1_q;
        data_meta_d = ps2Data;
        data_sync_d = data_meta_q;
        // Synchronised history 1,0,0 marks one clean falling edge.
        fall_d      = clk_d2_q && !clk_d1_q && !clk_sync_q;
        fall_data_d = data_sync_q;

        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_ok_d    = par_ok_q;
        timeout_d   = timeout_q;
        push_d      = 1'b0;
        frame_err_d = frame_err_q;
        overflow_d  = overflow_q;
        oe_d        = 1'b0;

        // Inter-edge watchdog, only armed while a frame is in progress.
        if (state_q == IDLE) begin
            timeout_d = '0;
        end else if (fall_q) begin
            timeout_d = '0;
        end else if (timeout_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_d   = '0;
            state_d     = IDLE;
            frame_err_d = 1'b1;
        end else begin
            timeout_d = timeout_q + TO_W'(1);
        end

        if (fall_q) begin
            unique case (state_q)
                IDLE: begin
                    if (!fall_data_q) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    // LSB arrives first, so shift right and insert at the top.
                    shift_d   = {fall_data_q, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_ok_d = ^{shift_q, fall_data_q};
                    state_d  = STOP;
                end
                STOP: begin
                    if (fall_data_q && par_ok_q) begin
                        push_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        // A pop in the same cycle makes room, so only an unmatched push on full drops.
        if (push_q && fifo_full && !rdStrobe) begin
            overflow_d = 1'b1;
        end

`ifdef PS2_INHIBIT_EN
        // Never asserted outside IDLE so an ongoing frame completes.
        oe_d = fifo_full && (state_q == IDLE);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_d1_q    <= 1'b1;
            clk_d2_q    <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            fall_q      <= 1'b0;
            fall_data_q <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_ok_q    <= 1'b0;
            timeout_q   <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            oe_q        <= 1'b0;
        end else begin
            clk_meta_q  <= clk_meta_d;
            clk_sync_q  <= clk_sync_d;
            clk_d1_q    <= clk_d1_d;
            clk_d2_q    <= clk_d2_d;
            data_meta_q <= data_meta_d;
            data_sync_q <= data_sync_d;
            fall_q      <= fall_d;
            fall_data_q <= fall_data_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_ok_q    <= par_ok_d;
            timeout_q   <= timeout_d;
            push_q      <= push_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            oe_q        <= oe_d;
        end
    end

    ps2_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (push_q),
        .wr_data   (shift_q),
        .rd_en     (rdStrobe),
        .rd_data_c (dataOut),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign dataValid = !fifo_empty;
    assign overflow  = overflow_q;
    assign frameErr  = frame_err_q;
    assign ps2ClkOe  = oe_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: scoreboard bench for ps2_rx_fifo. Frames are bit-banged on
// ps2Clk/ps2Data; accepted bytes are queued when sent and compared on pop.
module tb_ps2_rx_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TO    = 500;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2Clk;
    logic       ps2Data;
    logic       rdStrobe;
    logic [7:0] dataOut;
    logic       dataValid;
    logic       overflow;
    logic       frameErr;
    logic       ps2ClkOe;

    int errors = 0;
    int checks = 0;

    logic [7:0] sb [$];
    logic       exp_ovf;
    logic       exp_ferr;

    always #5 clk = ~clk;

    ps2_rx_fifo #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2Clk    (ps2Clk),
        .ps2Data   (ps2Data),
        .rdStrobe  (rdStrobe),
        .dataOut   (dataOut),
        .dataValid (dataValid),
        .overflow  (overflow),
        .frameErr  (frameErr),
        .ps2ClkOe  (ps2ClkOe)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_oe(input string tag, input logic full_idle);
        logic exp;
`ifdef PS2_INHIBIT_EN
        exp = full_idle;
`else
        exp = 1'b0;
`endif
        check(tag, ps2ClkOe, exp);
    endtask

    task automatic send_bit(input logic b);
        ps2Data = b;
        tick(5);
        ps2Clk = 1'b0;
        tick(10);
        ps2Clk = 1'b1;
        tick(5);
    endtask

    // Full frame; stop bit is split so the push cycle can be probed or popped against.
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit pop_mid, input bit chk_lat);
        logic [7:0] exp;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((~^d) ^ bad_par);
        ps2Data = 1'b1;
        tick(5);
        ps2Clk = 1'b0;
        tick(5);
        if (chk_lat) check("push_lat_early", dataValid, 1'b0);
        if (pop_mid) begin
            check("pop_mid_avail", dataValid, 1'b1);
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                check("pop_mid_data", dataOut, exp);
            end
            rdStrobe = 1'b1;
        end
        tick(1);
        rdStrobe = 1'b0;
        if (chk_lat) check("push_lat", dataValid, !bad_par);
        tick(4);
        ps2Clk = 1'b1;
        tick(5);
        if (bad_par) exp_ferr = 1'b1;
        else if (sb.size() < DEPTH) sb.push_back(d);
        else exp_ovf = 1'b1;
        check("overflow", overflow, exp_ovf);
        check("frame_err", frameErr, exp_ferr);
    endtask

    task automatic pop_one(input string tag);
        logic [7:0] exp;
        int n;
        n = 0;
        while (!dataValid && n < 200) begin
            tick(1);
            n++;
        end
        check({tag, "_valid"}, dataValid, 1'b1);
        if (sb.size() == 0) begin
            check({tag, "_extra"}, dataValid, 1'b0);
        end else begin
            exp = sb.pop_front();
            check({tag, "_data"}, dataOut, exp);
        end
        rdStrobe = 1'b1;
        tick(1);
        rdStrobe = 1'b0;
    endtask

    task automatic drain(input string tag);
        while (sb.size() > 0) pop_one(tag);
        tick(1);
        check({tag, "_empty"}, dataValid, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        sb.delete();
        exp_ovf  = 1'b0;
        exp_ferr = 1'b0;
        tick(1);
    endtask

    initial begin
        reset    = 1'b1;
        ps2Clk   = 1'b1;
        ps2Data  = 1'b1;
        rdStrobe = 1'b0;
        exp_ovf  = 1'b0;
        exp_ferr = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_valid", dataValid, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_ferr", frameErr, 1'b0);
        check("rst_oe", ps2ClkOe, 1'b0);

        // Good frame, push latency, single pop empties.
        send_frame(8'h1C, 1'b0, 1'b0, 1'b1);
        pop_one("f1c");
        tick(1);
        check("f1c_drained", dataValid, 1'b0);

        // Parity error: no push, sticky frameErr.
        send_frame(8'h1C, 1'b1, 1'b0, 1'b1);
        check("par_valid", dataValid, 1'b0);

        // Pop on empty is ignored; a later byte still comes through cleanly.
        rdStrobe = 1'b1;
        tick(1);
        rdStrobe = 1'b0;
        tick(1);
        check("empty_pop", dataValid, 1'b0);
        send_frame(8'h3A, 1'b0, 1'b0, 1'b1);
        drain("f3a");
        check("ferr_sticky", frameErr, 1'b1);

        do_reset();
        check("rst2_ferr", frameErr, 1'b0);

        // Truncated frame triggers the timeout, then a good frame follows.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        tick(TO - 50);
        check("to_early", frameErr, 1'b0);
        tick(100);
        exp_ferr = 1'b1;
        check("to_err", frameErr, 1'b1);
        check("to_valid", dataValid, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b1);
        drain("ff0");

        do_reset();

        // Nine frames into an eight-deep FIFO: the ninth is dropped.
        for (int k = 1; k <= 9; k++) begin
            send_frame(8'(k), 1'b0, 1'b0, 1'b0);
            if (k == 8) check_oe("oe_full8", 1'b1);
        end
        check_oe("oe_full9", 1'b1);
        pop_one("ovf");
        tick(3);
        check_oe("oe_release", 1'b0);
        drain("ovf");
        check("ovf_sticky", overflow, 1'b1);

        // Reset in the middle of a frame, then a clean frame.
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        do_reset();
        check("mid_rst_valid", dataValid, 1'b0);
        check("mid_rst_ovf", overflow, 1'b0);
        check("mid_rst_ferr", frameErr, 1'b0);
        check("mid_rst_oe", ps2ClkOe, 1'b0);
        send_frame(8'h29, 1'b0, 1'b0, 1'b1);
        drain("f29");

        do_reset();

        // Full FIFO with a pop in the push cycle: both succeed, no overflow.
        for (int k = 0; k < 8; k++) send_frame(8'h11 + 8'(k), 1'b0, 1'b0, 1'b0);
        check_oe("oe_full_b", 1'b1);
        send_frame(8'h55, 1'b0, 1'b1, 1'b0);
        check_oe("oe_full_c", 1'b1);
        check("simul_sb", 32'(sb.size()), 32'(DEPTH));
        drain("simul");
        check("simul_ovf", overflow, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
